i2c_master: RTL and testbench

- Single-transaction I2C master. After reset it issues START, a 7-bit slave address plus R/W bit, and checks the slave ACK.
- On ACK it reads one byte into data_out (rw=1) or writes one byte from data_in (rw=0), then issues STOP and parks in DONE.
- Exposes its FSM state for bench/debug. SDA is split into sda_in/sda_out; open-drain muxing lives at the top level.

---
 rtl/i2c_master.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_master.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// Single-transaction I2C master: START, address + R/W, ACK check, one data byte, STOP.
// Define I2C_MASTER_AUTO_RESTART_EN to return from DONE to IDLE after one cycle.
module i2c_master #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [2:0] state,
  output logic       sclk,
  input  logic       sda_in,
  output logic       sda_out
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDRESSING = 3'd1,
    WAITING    = 3'd2,
    READING    = 3'd3,
    WRITING    = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        sclk_q, sclk_d;
  logic        sda_q, sda_d;
  logic [7:0]  dout_q, dout_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  wr_q, wr_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic        lead_q, lead_d;
  logic        ack_q, ack_d;
  logic [1:0]  stop_q, stop_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sclk_q  <= 1'b1;
      sda_q   <= 1'b1;
      dout_q  <= 8'h00;
      cnt_q   <= 3'd7;
      tx_q    <= 8'h00;
      wr_q    <= 8'h00;
      rx_q    <= 8'h00;
      rw_q    <= 1'b0;
      lead_q  <= 1'b0;
      ack_q   <= 1'b0;
      stop_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      sda_q   <= sda_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rx_q    <= rx_d;
      rw_q    <= rw_d;
      lead_q  <= lead_d;
      ack_q   <= ack_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    sda_d   = sda_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    wr_d    = wr_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    lead_d  = lead_q;
    ack_d   = ack_q;
    stop_d  = stop_q;

    // STOP runs inside whichever state started it, so it takes priority.
    if (stop_q == 2'd1) begin
      sclk_d = 1'b1;
      sda_d  = 1'b0;
      stop_d = 2'd2;
    end else if (stop_q == 2'd2) begin
      sclk_d  = 1'b1;
      sda_d   = 1'b1;
      stop_d  = 2'd0;
      state_d = DONE;
    end else begin
      case (state_q)
        IDLE: begin
          rw_d    = rw;
          wr_d    = data_in;
          tx_d    = {SLAVE_ADDR, rw};
          cnt_d   = 3'd7;
          lead_d  = 1'b1;
          ack_d   = 1'b0;
          sclk_d  = 1'b1;
          sda_d   = 1'b0;
          state_d = ADDRESSING;
        end
        ADDRESSING: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // The edge ending the START condition drives bit 7 without counting.
            if (lead_q) begin
              lead_d = 1'b0;
              sda_d  = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end else if (cnt_q == 3'd0) begin
              sda_d   = 1'b1;
              state_d = WAITING;
            end else begin
              cnt_d = cnt_q - 3'd1;
              sda_d = tx_q[7];
              tx_d  = {tx_q[6:0], 1'b0};
            end
          end
        end
        WAITING: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            cnt_d  = 3'd7;
            if (sda_in) begin
              sda_d  = 1'b0;
              stop_d = 2'd1;
            end else if (rw_q) begin
              sda_d   = 1'b1;
              state_d = READING;
            end else begin
              sda_d   = wr_q[7];
              tx_d    = {wr_q[6:0], 1'b0};
              state_d = WRITING;
            end
          end
        end
        READING: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (ack_q) begin
              ack_d  = 1'b0;
              sda_d  = 1'b0;
              stop_d = 2'd1;
            end else begin
              rx_d  = {rx_q[6:0], sda_in};
              sda_d = 1'b1;
              if (cnt_q == 3'd0) begin
                dout_d = {rx_q[6:0], sda_in};
                ack_d  = 1'b1;
              end else begin
                cnt_d = cnt_q - 3'd1;
              end
            end
          end
        end
        WRITING: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // Slave ACK or NACK after the data byte both lead to STOP.
            if (ack_q) begin
              ack_d  = 1'b0;
              sda_d  = 1'b0;
              stop_d = 2'd1;
            end else if (cnt_q == 3'd0) begin
              ack_d = 1'b1;
              sda_d = 1'b1;
            end else begin
              cnt_d = cnt_q - 3'd1;
              sda_d = tx_q[7];
              tx_d  = {tx_q[6:0], 1'b0};
            end
          end
        end
        DONE: begin
          sclk_d = 1'b1;
          sda_d  = 1'b1;
`ifdef I2C_MASTER_AUTO_RESTART_EN
          state_d = IDLE;
`else
          state_d = DONE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign state    = state_q;
  assign sclk     = sclk_q;
  assign sda_out  = sda_q;
  assign data_out = dout_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed and randomized bench for i2c_master with a behavioural I2C slave
// that counts SCL rising edges and decodes the protocol from the bus alone.
module tb_i2c_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rw = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic [2:0] state;
  logic       sclk;
  logic       sda_in = 1'b1;
  logic       sda_out;

  always #5 clk = ~clk;

  i2c_master #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .rst      (rst),
    .rw       (rw),
    .data_in  (data_in),
    .data_out (data_out),
    .state    (state),
    .sclk     (sclk),
    .sda_in   (sda_in),
    .sda_out  (sda_out)
  );

  int checks = 0;
  int errs = 0;
  int cyc, starts, stops, bad, rises;
  logic prev_sclk, prev_sda;
  logic mbit [0:31];
  logic s_aa, s_ad;
  logic [7:0] s_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave response for the bit clocked by SCL rise number n after START.
  function automatic logic slave_bit(input int n);
    logic rd;
    rd = mbit[8];
    if (n == 9) return !s_aa;
    if (n >= 10 && n <= 17) return rd ? s_byte[17-n] : 1'b1;
    if (n == 18 && !rd) return !s_ad;
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (prev_sclk && sclk && (sda_out !== prev_sda)) begin
      if (!sda_out) begin
        starts++;
        rises = 0;
      end else begin
        stops++;
      end
    end
    if (!prev_sclk && sclk) begin
      rises++;
      if (sda_out !== prev_sda) bad++;
      if (rises < 32) mbit[rises] = sda_out;
    end
    prev_sclk = sclk;
    prev_sda  = sda_out;
    if (!sclk) sda_in = slave_bit(rises + 1);
  endtask

  task automatic txn(input logic r, input logic [7:0] d, input logic aa,
                     input logic ad, input logic [7:0] sb);
    logic [7:0] abyte, dbyte;
    int exp_cyc;
    rw = r; data_in = d; s_aa = aa; s_ad = ad; s_byte = sb; sda_in = 1'b1;
    rst = 1'b1;
    tick(); tick();
    starts = 0; stops = 0; bad = 0; rises = 0;
    prev_sclk = sclk; prev_sda = sda_out;
    for (int i = 0; i < 32; i++) mbit[i] = 1'b0;
    cyc = 0;
    rst = 1'b0;
    tick();
    rw = ~r; data_in = ~d;
    while (state !== 3'd5 && cyc < 200) tick();
    exp_cyc = 1 + 16 + 2 + (aa ? 16 + 2 : 0) + 3;
    chk("cycles_to_done", cyc, exp_cyc);
    chk("state_done", state, 3'd5);
    chk("sclk_done", sclk, 1'b1);
    chk("sda_done", sda_out, 1'b1);
    abyte = 8'h00;
    for (int i = 1; i <= 8; i++) abyte = {abyte[6:0], mbit[i]};
    chk("addr_byte", abyte, {7'h50, r});
    chk("ack_released", mbit[9], 1'b1);
    if (aa) begin
      dbyte = 8'h00;
      for (int i = 10; i <= 17; i++) dbyte = {dbyte[6:0], mbit[i]};
      chk("data_bits", dbyte, r ? 8'hFF : d);
      chk("bit18_released", mbit[18], 1'b1);
    end
    chk("data_out", data_out, (r && aa) ? sb : 8'h00);
    chk("start_count", starts, 1);
    chk("stop_count", stops, 1);
    chk("sda_on_rise", bad, 0);
    chk("scl_rises", rises, aa ? 19 : 10);
`ifndef I2C_MASTER_AUTO_RESTART_EN
    repeat (3) tick();
    chk("done_held", state, 3'd5);
    chk("done_dout_held", data_out, (r && aa) ? sb : 8'h00);
`endif
  endtask

  initial begin
    logic r, aa, ad;
    logic [7:0] d, sb;
    prev_sclk = 1'b1; prev_sda = 1'b1; cyc = 0; starts = 0; stops = 0; bad = 0; rises = 0;
    for (int i = 0; i < 32; i++) mbit[i] = 1'b0;
    s_aa = 1'b1; s_ad = 1'b1; s_byte = 8'h00;

    rst = 1'b1;
    tick(); tick();
    chk("rst_state", state, 3'd0);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_sda", sda_out, 1'b1);
    chk("rst_dout", data_out, 8'h00);

    txn(1'b1, 8'h00, 1'b1, 1'b1, 8'hF6);
`ifdef I2C_MASTER_AUTO_RESTART_EN
    tick();
    chk("auto_idle", state, 3'd0);
    tick();
    chk("auto_addr", state, 3'd1);
    chk("auto_start_sclk", sclk, 1'b1);
    chk("auto_start_sda", sda_out, 1'b0);
    chk("auto_dout_hold", data_out, 8'hF6);
`endif
    rst = 1'b1;
    tick();
    chk("rst_after_read_state", state, 3'd0);
    chk("rst_after_read_dout", data_out, 8'h00);

    txn(1'b0, 8'h3C, 1'b1, 1'b1, 8'h00);
    txn(1'b1, 8'h00, 1'b0, 1'b1, 8'hAA);
    txn(1'b0, 8'h96, 1'b1, 1'b0, 8'h00);

    for (int k = 0; k < 4; k++) begin
      r  = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      sb = 8'($urandom);
      aa = ($urandom_range(0, 3) != 0);
      ad = 1'($urandom_range(0, 1));
      txn(r, d, aa, ad, sb);
    end

    rw = 1'b1;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("mid_addr_state", state, 3'd1);
    chk("mid_addr_sclk_low", sclk, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_state", state, 3'd0);
    chk("mid_rst_sclk", sclk, 1'b1);
    chk("mid_rst_sda", sda_out, 1'b1);
    chk("mid_rst_dout", data_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
